// File: rtl/controlador_ajuste_if.sv
// Front-panel bus of the mode/adjust controller: debounced buttons and the
// one-second tick in, mode/field selection and counter enables out.
interface controlador_ajuste_if #(
  parameter int NUM_CANALES = 2,
  parameter int NUM_CAMPOS  = 2
);
  localparam int W_M = ($clog2(NUM_CANALES + 1) > 1) ? $clog2(NUM_CANALES + 1) : 1;
  localparam int W_C = ($clog2(NUM_CAMPOS) > 1) ? $clog2(NUM_CAMPOS) : 1;
  localparam int NA  = NUM_CANALES * NUM_CAMPOS;

  logic           i_tickSeg;
  logic           i_bModo;
  logic           i_bCampo;
  logic           i_bAumentar;
  logic [W_M-1:0] o_modo;
  logic [W_C-1:0] o_campoActual;
  logic [NA-1:0]  o_aumentar;
  logic           o_avanceTiempo;
  logic           o_parpadeo;

  modport master (
    output i_tickSeg, i_bModo, i_bCampo, i_bAumentar,
    input  o_modo, o_campoActual, o_aumentar, o_avanceTiempo, o_parpadeo
  );

  modport slave (
    input  i_tickSeg, i_bModo, i_bCampo, i_bAumentar,
    output o_modo, o_campoActual, o_aumentar, o_avanceTiempo, o_parpadeo
  );
endinterface

// File: rtl/controlador_ajuste.sv
// Mode/adjust controller for the digital clock: cycles run/set modes, selects the
// edited field, emits one-hot increment enables with auto-repeat and a set-mode timeout.
module controlador_ajuste #(
  parameter int NUM_CANALES = 2,
  parameter int NUM_CAMPOS  = 2,
  parameter int REP_DELAY   = 25_000_000,
  parameter int REP_PERIOD  = 5_000_000,
  parameter int TIMEOUT_SEG = 30
) (
  input logic                 i_clock,
  input logic                 i_reset,
  controlador_ajuste_if.slave bus
);
  localparam int W_M = ($clog2(NUM_CANALES + 1) > 1) ? $clog2(NUM_CANALES + 1) : 1;
  localparam int W_C = ($clog2(NUM_CAMPOS) > 1) ? $clog2(NUM_CAMPOS) : 1;
  localparam int W_I = W_M + W_C;
  localparam int NA  = NUM_CANALES * NUM_CAMPOS;

  localparam logic [W_M-1:0] MODO_MAX    = W_M'(NUM_CANALES);
  localparam logic [W_M-1:0] MODO_TIEMPO = W_M'(1);
  localparam logic [W_C-1:0] CAMPO_MAX   = W_C'(NUM_CAMPOS - 1);
  localparam logic [31:0]    DELAY_LAST  = 32'(REP_DELAY - 1);
  localparam logic [31:0]    PERIOD_LAST = 32'(REP_PERIOD - 1);
  localparam logic [31:0]    TO_LAST     = 32'(TIMEOUT_SEG - 1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_DELAY  = 2'd1,
    ST_WAIT_PERIOD = 2'd2
  } rep_state_t;

  logic           r_prev_modo, r_prev_campo, r_prev_aum;
  logic [W_M-1:0] r_modo, w_modo;
  logic [W_C-1:0] r_campo, w_campo;
  logic [NA-1:0]  r_aum, w_aum;
  logic           r_avance, w_avance;
  logic           r_parp, w_parp;
  logic [31:0]    r_rep_cnt, w_rep_cnt;
  logic [31:0]    r_to_cnt, w_to_cnt;
  rep_state_t     r_rep, w_rep;

  logic           w_edge_modo, w_edge_campo, w_edge_aum, w_set;
  logic [W_I-1:0] w_idx;
  logic [NA-1:0]  w_onehot;
  logic [31:0]    w_rep_last;

  assign w_edge_modo  = bus.i_bModo     & ~r_prev_modo;
  assign w_edge_campo = bus.i_bCampo    & ~r_prev_campo;
  assign w_edge_aum   = bus.i_bAumentar & ~r_prev_aum;
  assign w_set        = (r_modo != '0);
  assign w_idx        = ({{W_C{1'b0}}, r_modo} - W_I'(1)) * W_I'(NUM_CAMPOS)
                        + {{W_M{1'b0}}, r_campo};
  assign w_onehot     = NA'(1) << w_idx;
  assign w_rep_last   = (r_rep == ST_WAIT_DELAY) ? DELAY_LAST : PERIOD_LAST;

  // Next-state and output decode; button priority is modo > campo > aumentar > repeat/timeout.
  always_comb begin
    w_modo    = r_modo;
    w_campo   = r_campo;
    w_aum     = '0;
    w_parp    = r_parp;
    w_rep     = r_rep;
    w_rep_cnt = r_rep_cnt;
    w_to_cnt  = r_to_cnt;
    w_avance  = bus.i_tickSeg & (r_modo != MODO_TIEMPO);

    if (w_edge_modo) begin
      w_modo    = (r_modo == MODO_MAX) ? '0 : r_modo + W_M'(1);
      w_campo   = '0;
      w_to_cnt  = '0;
      w_rep     = ST_IDLE;
      w_rep_cnt = '0;
      w_parp    = 1'b1;
    end else if (w_edge_campo && w_set) begin
      w_campo   = (r_campo == CAMPO_MAX) ? '0 : r_campo + W_C'(1);
      w_to_cnt  = '0;
      w_rep     = ST_IDLE;
      w_rep_cnt = '0;
      w_parp    = 1'b1;
    end else if (w_edge_aum && w_set) begin
      w_aum     = w_onehot;
      w_rep     = ST_WAIT_DELAY;
      w_rep_cnt = '0;
      w_to_cnt  = '0;
      w_parp    = 1'b1;
    end else begin
      if (w_set && bus.i_tickSeg) begin
        w_parp = ~r_parp;
      end else begin
        w_parp = r_parp;
      end

      case (r_rep)
        ST_IDLE: begin
          w_rep_cnt = '0;
        end
        ST_WAIT_DELAY, ST_WAIT_PERIOD: begin
          if (!bus.i_bAumentar) begin
            w_rep     = ST_IDLE;
            w_rep_cnt = '0;
          end else if (r_rep_cnt == w_rep_last) begin
            w_aum     = w_onehot;
            w_parp    = 1'b1;
            w_rep     = ST_WAIT_PERIOD;
            w_rep_cnt = '0;
          end else begin
            w_rep_cnt = r_rep_cnt + 32'd1;
          end
        end
        default: begin
          w_rep     = ST_IDLE;
          w_rep_cnt = '0;
        end
      endcase

      // Timeout overrides a repeat pulse landing on the same cycle.
      if (w_set && (TIMEOUT_SEG != 0) && bus.i_tickSeg) begin
        if (r_to_cnt == TO_LAST) begin
          w_modo    = '0;
          w_campo   = '0;
          w_aum     = '0;
          w_rep     = ST_IDLE;
          w_rep_cnt = '0;
          w_to_cnt  = '0;
          w_parp    = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + 32'd1;
        end
      end else begin
        w_to_cnt = r_to_cnt;
      end

      if (!w_set) begin
        w_parp   = 1'b1;
        w_to_cnt = '0;
      end else begin
        w_parp = w_parp;
      end
    end
  end

  // State and output registers; previous samples reset high so a held button gives no edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev_modo  <= 1'b1;
      r_prev_campo <= 1'b1;
      r_prev_aum   <= 1'b1;
      r_modo       <= '0;
      r_campo      <= '0;
      r_aum        <= '0;
      r_avance     <= 1'b0;
      r_parp       <= 1'b1;
      r_rep        <= ST_IDLE;
      r_rep_cnt    <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_prev_modo  <= bus.i_bModo;
      r_prev_campo <= bus.i_bCampo;
      r_prev_aum   <= bus.i_bAumentar;
      r_modo       <= w_modo;
      r_campo      <= w_campo;
      r_aum        <= w_aum;
      r_avance     <= w_avance;
      r_parp       <= w_parp;
      r_rep        <= w_rep;
      r_rep_cnt    <= w_rep_cnt;
      r_to_cnt     <= w_to_cnt;
    end
  end

  assign bus.o_modo         = r_modo;
  assign bus.o_campoActual  = r_campo;
  assign bus.o_aumentar     = r_aum;
  assign bus.o_avanceTiempo = r_avance;
  assign bus.o_parpadeo     = r_parp;
endmodule
